// File: rtl/present_dec.sv
// present_dec -- iterative PRESENT-80 block decryptor, one round per clock.
//
// The 80-bit user key is first run forward through the encryption key
// schedule to reach K32. The block is whitened with K32, and the 31 inverse
// rounds then walk the key register back one step per round.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   ciphertext/key offered
//   in_ready   core idle and able to accept (high only in IDLE)
//   ciphertext 64-bit block to decrypt
//   key        80-bit PRESENT-80 user key
//   out_valid  plaintext valid; held until out_ready
//   out_ready  consumer accepts plaintext
//   plaintext  64-bit decrypted block
//
// Latency is 63 cycles from the accept edge to out_valid.
//
// Optional build macro: PRESENT_DEC_KEY_CACHE_EN
//   This macro remembers the last key together with its K32. When the
//   accepted key matches the remembered key, the forward key schedule is
//   skipped and latency drops to 32 cycles. The remembered key is cleared
//   by rst.

module present_dec #(
  parameter int unsigned ROUNDS = 31,
  parameter int unsigned CNT_W  = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] ciphertext,
  input  logic [79:0] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] plaintext
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY_FWD,
    S_ADD_LAST,
    S_ROUND,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_RC = CNT_W'(ROUNDS);
  localparam logic [CNT_W-1:0] ONE_RC  = CNT_W'(1);

  state_t            state;
  logic [63:0]       st;
  logic [79:0]       kr;
  logic [CNT_W-1:0]  cnt;

  logic [79:0]       kr_fwd;
  logic [79:0]       kr_inv;
  logic [63:0]       st_round;

  // ---------------------------------------------------------------------------
  // Primitive functions
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
    endcase
    return y;
  endfunction

  function automatic logic [63:0] inv_sbox_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      y[4*i +: 4] = inv_sbox(x[4*i +: 4]);
    end
    return y;
  endfunction

  // The forward permutation moves bit i to position 16*i mod 63. Pulling each
  // output bit from that source position undoes it; bit 63 is fixed.
  function automatic logic [63:0] inv_player(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int unsigned j = 0; j < 63; j++) begin
      y[j] = x[(16 * j) % 63];
    end
    y[63] = x[63];
    return y;
  endfunction

  // Forward key update: rotate left 61, S-box the top nibble, add the round
  // counter into bits 19:15.
  function automatic logic [79:0] key_fwd(input logic [79:0] k,
                                          input logic [4:0]  rc);
    logic [79:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = sbox(r[79:76]);
    r[19:15]   = r[19:15] ^ rc;
    return r;
  endfunction

  // Exact inverse of key_fwd for the same counter value.
  function automatic logic [79:0] key_inv(input logic [79:0] k,
                                          input logic [4:0]  rc);
    logic [79:0] t;
    t          = k;
    t[19:15]   = t[19:15] ^ rc;
    t[79:76]   = inv_sbox(t[79:76]);
    return {t[60:0], t[79:61]};
  endfunction

  // ---------------------------------------------------------------------------
  // Round datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    kr_fwd   = key_fwd(kr, cnt[4:0]);
    kr_inv   = key_inv(kr, cnt[4:0]);
    st_round = inv_sbox_layer(inv_player(st)) ^ kr_inv[79:16];
  end

`ifdef PRESENT_DEC_KEY_CACHE_EN
  logic [79:0] last_key;
  logic [79:0] k32_cache;
  logic        cache_vld;
  logic        cache_hit;

  always_comb begin
    cache_hit = cache_vld && (key == last_key);
  end
`endif

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      plaintext <= '0;
      st        <= '0;
      kr        <= '0;
      cnt       <= '0;
`ifdef PRESENT_DEC_KEY_CACHE_EN
      last_key  <= '0;
      k32_cache <= '0;
      cache_vld <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            st       <= ciphertext;
            in_ready <= 1'b0;
`ifdef PRESENT_DEC_KEY_CACHE_EN
            if (cache_hit) begin
              kr    <= k32_cache;
              cnt   <= LAST_RC;
              state <= S_ADD_LAST;
            end else begin
              // Invalidate now. Revalidate once K32 for this key exists, so
              // an abort in between cannot leave a stale pairing behind.
              kr        <= key;
              cnt       <= ONE_RC;
              last_key  <= key;
              cache_vld <= 1'b0;
              state     <= S_KEY_FWD;
            end
`else
            kr    <= key;
            cnt   <= ONE_RC;
            state <= S_KEY_FWD;
`endif
          end
        end

        S_KEY_FWD: begin
          kr <= kr_fwd;
          if (cnt == LAST_RC) begin
            // The counter stays at the last round number, which is the first
            // value the inverse walk needs.
            state <= S_ADD_LAST;
`ifdef PRESENT_DEC_KEY_CACHE_EN
            k32_cache <= kr_fwd;
            cache_vld <= 1'b1;
`endif
          end else begin
            cnt <= cnt + ONE_RC;
          end
        end

        S_ADD_LAST: begin
          st    <= st ^ kr[79:16];
          state <= S_ROUND;
        end

        S_ROUND: begin
          st  <= st_round;
          kr  <= kr_inv;
          cnt <= cnt - ONE_RC;
          if (cnt == ONE_RC) begin
            plaintext <= st_round;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end

        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_present_dec.sv
// tb_present_dec -- directed test of present_dec against the published
// PRESENT-80 test vectors. Also covers latency, backpressure, in_valid being
// ignored while busy, and mid-operation reset.

module tb_present_dec;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] ciphertext;
  logic [79:0] key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] plaintext;

  int errors;
  int checks;

  localparam logic [79:0] KEY0 = 80'h0;
  localparam logic [79:0] KEYF = {80{1'b1}};
  localparam logic [63:0] PT0  = 64'h0;
  localparam logic [63:0] PTF  = 64'hFFFF_FFFF_FFFF_FFFF;

  localparam int LAT_FULL = 63;
`ifdef PRESENT_DEC_KEY_CACHE_EN
  localparam int LAT_HIT  = 32;
`else
  localparam int LAT_HIT  = 63;
`endif

  present_dec #(.ROUNDS(31), .CNT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ciphertext (ciphertext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .plaintext  (plaintext)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Offer one block and wait for its result. Optionally hold out_ready low
  // for `hold` cycles while driving a bogus request, then complete the
  // handshake.
  task automatic run_block(input string tag, input logic [63:0] ct, input logic [79:0] k,
                           input logic [63:0] exp_pt, input int exp_lat, input int hold);
    int cyc;
    chk({tag, " ready_before"}, 80'(in_ready), 80'(1));
    in_valid   = 1'b1;
    ciphertext = ct;
    key        = k;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    ciphertext = '0;
    key        = '0;
    chk({tag, " ready_busy"}, 80'(in_ready), 80'(0));
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " latency"}, 80'(cyc), 80'(exp_lat));
    chk({tag, " plaintext"}, 80'(plaintext), 80'(exp_pt));
    if (hold > 0) begin
      in_valid   = 1'b1;
      ciphertext = 64'hDEAD_BEEF_0123_4567;
      key        = 80'h1234_5678_9ABC_DEF0_1357;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk({tag, " hold_valid"}, 80'(out_valid), 80'(1));
        chk({tag, " hold_ready"}, 80'(in_ready), 80'(0));
        chk({tag, " hold_pt"}, 80'(plaintext), 80'(exp_pt));
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready  = 1'b0;
    in_valid   = 1'b0;
    ciphertext = '0;
    key        = '0;
    chk({tag, " post_valid"}, 80'(out_valid), 80'(0));
    chk({tag, " post_ready"}, 80'(in_ready), 80'(1));
    chk({tag, " post_pt"}, 80'(plaintext), 80'(exp_pt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    errors     = 0;
    checks     = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    ciphertext = '0;
    key        = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 80'(in_ready), 80'(1));
    chk("reset out_valid", 80'(out_valid), 80'(0));
    chk("reset plaintext", 80'(plaintext), 80'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    run_block("k0_pt0", 64'h5579_C138_7B22_8445, KEY0, PT0, LAT_FULL, 0);
    run_block("k0_ptF", 64'hA112_FFC7_2F68_417B, KEY0, PTF, LAT_HIT, 0);
    run_block("kF_pt0", 64'hE72C_46C0_F594_5049, KEYF, PT0, LAT_FULL, 0);
    run_block("kF_ptF_bp", 64'h3333_DCD3_2132_10D2, KEYF, PTF, LAT_HIT, 10);

    // Abort a decrypt 20 cycles after accept.
    in_valid   = 1'b1;
    ciphertext = 64'hE72C_46C0_F594_5049;
    key        = KEYF;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    ciphertext = '0;
    key        = '0;
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort out_valid", 80'(out_valid), 80'(0));
    chk("abort in_ready", 80'(in_ready), 80'(1));
    chk("abort plaintext", 80'(plaintext), 80'(0));
    #2;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("abort no_pulse", 80'(out_valid), 80'(0));

    // Reset also drops any remembered key, so this is a full-latency run.
    run_block("kF_pt0_after_rst", 64'hE72C_46C0_F594_5049, KEYF, PT0, LAT_FULL, 0);
    run_block("k0_pt0_keychg", 64'h5579_C138_7B22_8445, KEY0, PT0, LAT_FULL, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
